// File: rtl/morse_keyer.sv
// Timed Morse keyer: plays one latched element pattern onto a key line with
// unit-based mark/space/gap timing and a start/busy/done handshake.
module morse_keyer #(
   parameter int MAX_LEN     = 5,
   parameter int UNIT_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [MAX_LEN-1:0] mask,
   output logic               tone,
   output logic               cur_dot,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = $clog2(3 * UNIT_CYCLES + 1);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [CNT_W-1:0] UNIT_LAST   = CNT_W'(UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TRIPLE_LAST = CNT_W'(3 * UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic [MAX_LEN-1:0]   pat_r, pat_s;
   logic [MAX_LEN-1:0]   rem_r, rem_s;
   logic                 tone_r, cur_dot_r, busy_r, done_r;
   logic                 dot_s, done_s;
   logic [IDX_W-1:0]     sel_s;

   // Highest set bit of a mask; the caller guarantees the mask is non-zero.
   function automatic logic [IDX_W-1:0] top_idx(input logic [MAX_LEN-1:0] m);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = 0; i < MAX_LEN; i++) begin
         if (m[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   function automatic logic [MAX_LEN-1:0] bit_at(input logic [IDX_W-1:0] idx);
      logic [MAX_LEN-1:0] v;
      for (int i = 0; i < MAX_LEN; i++) begin
         v[i] = (IDX_W'(i) == idx);
      end
      return v;
   endfunction

   function automatic logic [CNT_W-1:0] mark_last(input logic dot);
      return dot ? UNIT_LAST : TRIPLE_LAST;
   endfunction

   // Next-state, counter and element-selection logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      pat_s   = pat_r;
      rem_s   = rem_r;
      dot_s   = cur_dot_r;
      done_s  = 1'b0;
      sel_s   = {IDX_W{1'b0}};
      case (state_r)
         IDLE: begin
            if (start) begin
               pat_s = pattern;
               if (|mask) begin
                  sel_s   = top_idx(mask);
                  rem_s   = mask & ~bit_at(sel_s);
                  dot_s   = pattern[sel_s];
                  state_s = MARK;
                  cnt_s   = mark_last(pattern[sel_s]);
               end else begin
                  rem_s   = mask;
                  dot_s   = 1'b0;
                  state_s = GAP;
                  cnt_s   = TRIPLE_LAST;
               end
            end else begin
               state_s = IDLE;
            end
         end
         MARK: begin
            if (cnt_r == CNT_ZERO) begin
               dot_s = 1'b0;
               if (|rem_r) begin
                  state_s = SPACE;
                  cnt_s   = UNIT_LAST;
               end else begin
                  state_s = GAP;
                  cnt_s   = TRIPLE_LAST;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         SPACE: begin
            if (cnt_r == CNT_ZERO) begin
               sel_s   = top_idx(rem_r);
               rem_s   = rem_r & ~bit_at(sel_s);
               dot_s   = pat_r[sel_s];
               state_s = MARK;
               cnt_s   = mark_last(pat_r[sel_s]);
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         GAP: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = IDLE;
               done_s  = 1'b1;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            dot_s   = 1'b0;
         end
      endcase
   end

   // State, latched character and registered Moore outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         pat_r     <= {MAX_LEN{1'b0}};
         rem_r     <= {MAX_LEN{1'b0}};
         tone_r    <= 1'b0;
         cur_dot_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         pat_r     <= pat_s;
         rem_r     <= rem_s;
         tone_r    <= (state_s == MARK);
         cur_dot_r <= (state_s == MARK) && dot_s;
         busy_r    <= (state_s != IDLE);
         done_r    <= done_s;
      end
   end

   assign tone    = tone_r;
   assign cur_dot = cur_dot_r;
   assign busy    = busy_r;
   assign done    = done_r;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: per-cycle comparison against a timeline model built
// from the Morse timing rules, plus literal busy/done/tone counts per character.
module tb_morse_keyer;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] start_v;
   logic [7:0] mask_v [2];
   logic [7:0] pat_v  [2];
   logic       tone0, dot0, busy0, done0;
   logic       tone1, dot1, busy1, done1;
   logic       cmp_en = 1'b0;
   int         checks = 0;
   int         errors = 0;

   // model: {tone, cur_dot, busy, done} expected per cycle
   logic [3:0] cur [2];
   logic [3:0] mq0 [$];
   logic [3:0] mq1 [$];
   logic [3:0] tl_q [$];

   always #5 clk = ~clk;

   morse_keyer #(.MAX_LEN(5), .UNIT_CYCLES(4)) dut0 (
      .clk(clk), .reset(reset), .start(start_v[0]),
      .pattern(pat_v[0][4:0]), .mask(mask_v[0][4:0]),
      .tone(tone0), .cur_dot(dot0), .busy(busy0), .done(done0));

   morse_keyer #(.MAX_LEN(6), .UNIT_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .start(start_v[1]),
      .pattern(pat_v[1][5:0]), .mask(mask_v[1][5:0]),
      .tone(tone1), .cur_dot(dot1), .busy(busy1), .done(done1));

   function automatic logic [3:0] outs(input int k);
      return (k == 0) ? {tone0, dot0, busy0, done0} : {tone1, dot1, busy1, done1};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Timeline of a character: marks MSB first, a unit space between marks,
   // then a three-unit gap, then the single done cycle.
   function automatic void build(input int len, input int unit,
                                 input logic [7:0] m, input logic [7:0] p);
      bit first;
      first = 1'b1;
      tl_q.delete();
      for (int i = len - 1; i >= 0; i--) begin
         if (m[i]) begin
            if (!first) begin
               for (int j = 0; j < unit; j++) tl_q.push_back(4'b0010);
            end
            for (int j = 0; j < (p[i] ? 1 : 3) * unit; j++)
               tl_q.push_back({1'b1, p[i], 1'b1, 1'b0});
            first = 1'b0;
         end
      end
      for (int j = 0; j < 3 * unit; j++) tl_q.push_back(4'b0010);
      tl_q.push_back(4'b0001);
   endfunction

   initial begin
      cur[0] = 4'b0000;
      cur[1] = 4'b0000;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            mq0.delete();
            mq1.delete();
            cur[0] = 4'b0000;
            cur[1] = 4'b0000;
         end else begin
            if (!cur[0][1] && start_v[0]) begin
               build(5, 4, mask_v[0], pat_v[0]);
               foreach (tl_q[i]) mq0.push_back(tl_q[i]);
            end
            cur[0] = (mq0.size() > 0) ? mq0.pop_front() : 4'b0000;
            if (!cur[1][1] && start_v[1]) begin
               build(6, 1, mask_v[1], pat_v[1]);
               foreach (tl_q[i]) mq1.push_back(tl_q[i]);
            end
            cur[1] = (mq1.size() > 0) ? mq1.pop_front() : 4'b0000;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("model_k0", {28'd0, outs(0)}, {28'd0, cur[0]});
            check("model_k1", {28'd0, outs(1)}, {28'd0, cur[1]});
         end
      end
   end

   // mode 0: single start pulse; 1: extra pulses at cycles 3 and 10; 2: start held through done
   task automatic run(input string name, input int k, input logic [7:0] m, input logic [7:0] p,
                      input int exp_busy, input int exp_done, input int exp_tone,
                      input int exp_marks, input int mode);
      int         bcnt, tcnt, mcnt, dat, seen;
      logic       prev;
      logic [3:0] o;
      @(negedge clk);
      mask_v[k]  = m;
      pat_v[k]   = p;
      start_v[k] = 1'b1;
      bcnt = 0; tcnt = 0; mcnt = 0; dat = 0; prev = 1'b0;
      for (int n = 1; n <= 200 && dat == 0; n++) begin
         @(negedge clk);
         if (n == 2) begin
            mask_v[k] = ~m;
            pat_v[k]  = ~p;
         end else if (n == 5) begin
            mask_v[k] = m;
            pat_v[k]  = p;
         end else begin
            mask_v[k] = mask_v[k];
         end
         start_v[k] = (mode == 2) || (mode == 1 && (n == 3 || n == 10));
         o = outs(k);
         if (o[1]) bcnt++;
         if (o[3]) tcnt++;
         if (o[3] && !prev) mcnt++;
         prev = o[3];
         if (o[0]) dat = n;
      end
      check({name, "_busy_cycles"}, bcnt, exp_busy);
      check({name, "_done_cycle"}, dat, exp_done);
      check({name, "_tone_cycles"}, tcnt, exp_tone);
      check({name, "_marks"}, mcnt, exp_marks);
      if (mode == 2) begin
         @(negedge clk);
         check({name, "_rearm_tone"}, {31'd0, outs(k)[3]}, 32'd1);
         start_v[k] = 1'b0;
         seen = 0;
         for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk);
            if (outs(k)[0]) seen = 1;
         end
         check({name, "_rearm_done"}, seen, 1);
      end
      start_v[k] = 1'b0;
   endtask

   initial begin
      int dcnt;
      reset     = 1'b1;
      start_v   = 2'b00;
      mask_v[0] = 8'h00; mask_v[1] = 8'h00;
      pat_v[0]  = 8'h00; pat_v[1]  = 8'h00;
      repeat (2) @(negedge clk);
      check("reset_k0", {28'd0, outs(0)}, 32'd0);
      check("reset_k1", {28'd0, outs(1)}, 32'd0);
      reset  = 1'b0;
      cmp_en = 1'b1;

      run("A",      0, 8'b00011000, 8'b00010111, 32, 33, 16, 2, 0);
      run("T",      0, 8'b00010000, 8'b00001111, 24, 25, 12, 1, 0);
      run("empty",  0, 8'b00000000, 8'b00011111, 12, 13,  0, 0, 0);
      run("five",   0, 8'b00011111, 8'b00011111, 48, 49, 20, 5, 0);
      run("sparse", 0, 8'b00010100, 8'b00010011, 32, 33, 16, 2, 0);
      run("A_poke", 0, 8'b00011000, 8'b00010000, 32, 33, 16, 2, 1);
      run("A_hold", 0, 8'b00011000, 8'b00010000, 32, 33, 16, 2, 2);

      // abort mid-dash
      @(negedge clk);
      mask_v[0]  = 8'b00011000;
      pat_v[0]   = 8'b00010000;
      start_v[0] = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         start_v[0] = 1'b0;
      end
      check("abort_pre_tone", {31'd0, tone0}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_tone", {31'd0, tone0}, 32'd0);
      check("abort_busy", {31'd0, busy0}, 32'd0);
      check("abort_dot",  {31'd0, dot0},  32'd0);
      @(negedge clk);
      reset = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done0) dcnt++;
      end
      check("abort_no_done", dcnt, 0);
      run("A_after", 0, 8'b00011000, 8'b00010000, 32, 33, 16, 2, 0);

      run("u1_len6", 1, 8'b00111111, 8'b00010101, 20, 21, 12, 6, 0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
